// File: rtl/root_arbiter_if.sv
// Bus bundle between the requesters, the shared square-root pipeline,
// the result consumer and the root_arbiter.
interface root_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]   Req_Valid;
  logic [8*N_REQ-1:0] Req_Data;
  logic [N_REQ-1:0]   Req_Ready;
  logic [7:0]         Root_X;
  logic [3:0]         Root_C;
  logic               Res_Valid;
  logic [ID_W-1:0]    Res_Id;
  logic [3:0]         Res_Data;
  logic               Res_Ready;
  logic               Busy;

  // Arbiter side
  modport slave (
    input  Req_Valid, Req_Data, Root_C, Res_Ready,
    output Req_Ready, Root_X, Res_Valid, Res_Id, Res_Data, Busy
  );

  // Environment side: requesters, pipeline and result consumer
  modport master (
    output Req_Valid, Req_Data, Root_C, Res_Ready,
    input  Req_Ready, Root_X, Res_Valid, Res_Id, Res_Data, Busy
  );
endinterface

// File: rtl/root_arbiter.sv
// Round-robin arbiter sharing one fixed-latency sqrt pipeline among N_REQ
// requesters; results are tagged with the requester id and buffered in an
// in-order FIFO whose head entry drives the result outputs.
module root_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LAT   = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic          Clk,
  input  logic          Rst_n,
  root_arbiter_if.slave bus
);
  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [3:0]      data;
  } fifo_entry_t;

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [OCC_W-1:0] cnt_q, cnt_d;
  logic [OCC_W-1:0] wr_idx;
  logic             busy_q, res_valid_q;
  logic [LAT-1:0]   pipe_vld_q;
  logic [ID_W-1:0]  pipe_id_q [LAT];
  fifo_entry_t      fifo_q [DEPTH];
  fifo_entry_t      fifo_d [DEPTH];

  logic             gnt_any;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  idx;
  logic [N_REQ-1:0] req_ready_c;
  logic [7:0]       root_x_c;
  logic             push, pop;

  // Round-robin search from ptr_q, gated by reset and occupancy
  always_comb begin
    gnt_any     = 1'b0;
    gnt_id      = '0;
    idx         = '0;
    req_ready_c = '0;
    root_x_c    = 8'd0;
    if (Rst_n && (occ_q < OCC_W'(DEPTH))) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        idx = ptr_q + ID_W'(k);
        if (!gnt_any && bus.Req_Valid[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = idx;
        end
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_any && (gnt_id == ID_W'(i))) begin
        req_ready_c[i] = 1'b1;
        root_x_c       = bus.Req_Data[8*i +: 8];
      end
    end
  end

  assign bus.Req_Ready = req_ready_c;
  assign bus.Root_X    = root_x_c;

  assign push = pipe_vld_q[LAT-1];
  assign pop  = res_valid_q && bus.Res_Ready;

  // Next pointer, occupancy and FIFO contents
  always_comb begin
    ptr_d  = ptr_q;
    occ_d  = occ_q;
    cnt_d  = cnt_q;
    fifo_d = fifo_q;
    wr_idx = cnt_q;
    if (gnt_any) ptr_d = gnt_id + ID_W'(1);
    case ({gnt_any, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    if (pop) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) fifo_d[i] = fifo_q[i+1];
      cnt_d  = cnt_q - OCC_W'(1);
      wr_idx = cnt_q - OCC_W'(1);
    end
    // Pipeline output is only captured when its tagged valid bit is set
    if (push) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_idx == OCC_W'(i)) fifo_d[i] = '{id: pipe_id_q[LAT-1], data: bus.Root_C};
      end
      cnt_d = cnt_d + OCC_W'(1);
    end
  end

  // State registers; reset discards everything in flight
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr_q       <= '0;
      occ_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      pipe_vld_q  <= '0;
      for (int unsigned s = 0; s < LAT; s++) pipe_id_q[s] <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      occ_q       <= occ_d;
      cnt_q       <= cnt_d;
      busy_q      <= (occ_d != '0);
      res_valid_q <= (cnt_d != '0);
      pipe_vld_q[0] <= gnt_any;
      pipe_id_q[0]  <= gnt_id;
      for (int unsigned s = 1; s < LAT; s++) begin
        pipe_vld_q[s] <= pipe_vld_q[s-1];
        pipe_id_q[s]  <= pipe_id_q[s-1];
      end
      fifo_q <= fifo_d;
    end
  end

  assign bus.Res_Valid = res_valid_q;
  assign bus.Res_Id    = fifo_q[0].id;
  assign bus.Res_Data  = fifo_q[0].data;
  assign bus.Busy      = busy_q;

endmodule

// File: tb/tb_root_arbiter.sv
// Directed scoreboard bench for root_arbiter with a behavioural sqrt pipeline.
module tb_root_arbiter;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 8;

  logic Clk;
  logic Rst_n;
  int   errors = 0;
  int   checks = 0;

  logic [5:0] sb_q[$];
  logic [5:0] mon_exp;
  logic [3:0] rc_pipe [LAT];

  root_arbiter_if #(.N_REQ(N_REQ)) bus ();

  root_arbiter #(.N_REQ(N_REQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [3:0] isqrt(input logic [7:0] x);
    logic [3:0] r;
    r = 4'd0;
    for (int k = 1; k < 16; k++) if (k * k <= int'(x)) r = 4'(k);
    return r;
  endfunction

  // Fixed-latency sqrt pipeline; not reset, so stale values keep flowing
  initial for (int s = 0; s < int'(LAT); s++) rc_pipe[s] = 4'd0;
  always @(posedge Clk) begin
    rc_pipe[0] <= isqrt(bus.Root_X);
    for (int s = 1; s < int'(LAT); s++) rc_pipe[s] <= rc_pipe[s-1];
  end
  assign bus.Root_C = rc_pipe[LAT-1];

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every accepted result must match the head of the scoreboard
  always @(negedge Clk) begin
    if (Rst_n && bus.Res_Valid && bus.Res_Ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual id=%0d data=%0d required=none",
                 bus.Res_Id, bus.Res_Data);
      end else begin
        mon_exp = sb_q.pop_front();
        check("res_id",   32'(bus.Res_Id),   32'(mon_exp[5:4]));
        check("res_data", 32'(bus.Res_Data), 32'(mon_exp[3:0]));
      end
    end
  end

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    bus.Req_Valid = '0;
    bus.Req_Data  = '0;
    bus.Res_Ready = 1'b1;
    next_cycle();
    next_cycle();
    Rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    bus.Req_Valid = '0;
    bus.Res_Ready = 1'b1;
    while ((sb_q.size() != 0 || bus.Busy) && n < 40) begin
      next_cycle();
      n++;
    end
    check({name, "_pending"}, 32'(sb_q.size()), 0);
    @(negedge Clk);
    check({name, "_busy_idle"}, 32'(bus.Busy), 0);
    next_cycle();
  endtask

  initial begin
    logic [7:0] vals [4];
    logic [3:0] roots [4];

    // Reset state with requests pending
    Rst_n = 1'b0;
    bus.Req_Valid = 4'b1111;
    bus.Req_Data  = 32'h11223344;
    bus.Res_Ready = 1'b1;
    @(negedge Clk);
    check("rst_req_ready", 32'(bus.Req_Ready), 0);
    check("rst_root_x",    32'(bus.Root_X),    0);
    check("rst_res_valid", 32'(bus.Res_Valid), 0);
    check("rst_res_id",    32'(bus.Res_Id),    0);
    check("rst_res_data",  32'(bus.Res_Data),  0);
    check("rst_busy",      32'(bus.Busy),      0);
    do_reset();

    // Single request: 200 -> 14, result in cycle 5, busy cycles 1..5
    for (int c = 0; c < 8; c++) begin
      bus.Req_Valid = (c == 0) ? 4'b0001 : 4'b0000;
      bus.Req_Data  = 32'd200;
      if (c == 0) sb_q.push_back({2'd0, 4'd14});
      @(negedge Clk);
      if (c == 0) begin
        check("single_grant",  32'(bus.Req_Ready), 32'b0001);
        check("single_root_x", 32'(bus.Root_X),    200);
      end
      check($sformatf("single_busy_c%0d", c),  32'(bus.Busy),      (c >= 1 && c <= 5) ? 1 : 0);
      check($sformatf("single_valid_c%0d", c), 32'(bus.Res_Valid), (c == 5) ? 1 : 0);
      next_cycle();
    end
    drain("single");

    // Contention: all four valid, grants rotate 0,1,2,3
    do_reset();
    vals  = '{8'd255, 8'd64, 8'd15, 8'd0};
    roots = '{4'd15, 4'd8, 4'd3, 4'd0};
    for (int c = 0; c < 15; c++) begin
      bus.Req_Valid = (c < 8) ? 4'b1111 : 4'b0000;
      bus.Req_Data  = {vals[3], vals[2], vals[1], vals[0]};
      if (c < 8) sb_q.push_back({2'(c % 4), roots[c % 4]});
      @(negedge Clk);
      if (c < 8) begin
        check($sformatf("cont_grant_c%0d", c),  32'(bus.Req_Ready), 32'(1 << (c % 4)));
        check($sformatf("cont_root_x_c%0d", c), 32'(bus.Root_X),    32'(vals[c % 4]));
      end else begin
        check($sformatf("cont_grant_c%0d", c), 32'(bus.Req_Ready), 0);
      end
      check($sformatf("cont_valid_c%0d", c), 32'(bus.Res_Valid), (c >= 5 && c <= 12) ? 1 : 0);
      next_cycle();
    end
    drain("cont");

    // Backpressure: requester 2 with 99, consumer stalled until cycle 12
    do_reset();
    for (int c = 0; c < 14; c++) begin
      bus.Req_Valid = 4'b0100;
      bus.Req_Data  = {8'd0, 8'd99, 8'd0, 8'd0};
      bus.Res_Ready = (c >= 12);
      if (c < 8 || c == 13) sb_q.push_back({2'd2, 4'd9});
      @(negedge Clk);
      check($sformatf("bp_grant_c%0d", c), 32'(bus.Req_Ready),
            (c < 8 || c == 13) ? 32'b0100 : 0);
      if (c >= 5) begin
        check($sformatf("bp_valid_c%0d", c), 32'(bus.Res_Valid), 1);
        check($sformatf("bp_data_c%0d", c),  32'(bus.Res_Data),  9);
        check($sformatf("bp_id_c%0d", c),    32'(bus.Res_Id),    2);
      end
      next_cycle();
    end
    drain("bp");

    // Fairness: requesters 1 and 3 alternate
    do_reset();
    for (int c = 0; c < 8; c++) begin
      bus.Req_Valid = 4'b1010;
      bus.Req_Data  = {8'd81, 8'd0, 8'd16, 8'd0};
      if (c % 2 == 0) sb_q.push_back({2'd1, 4'd4});
      else            sb_q.push_back({2'd3, 4'd9});
      @(negedge Clk);
      check($sformatf("fair_grant_c%0d", c), 32'(bus.Req_Ready),
            (c % 2 == 0) ? 32'b0010 : 32'b1000);
      next_cycle();
    end
    drain("fair");

    // Reset mid-operation: three issues in flight are discarded
    do_reset();
    for (int c = 0; c < 3; c++) begin
      bus.Req_Valid = 4'b0001;
      bus.Req_Data  = 32'd200;
      @(negedge Clk);
      check($sformatf("midrst_grant_c%0d", c), 32'(bus.Req_Ready), 32'b0001);
      next_cycle();
    end
    bus.Req_Valid = 4'b1001;
    bus.Req_Data  = {8'd36, 8'd0, 8'd0, 8'd49};
    Rst_n = 1'b0;
    @(negedge Clk);
    check("midrst_ready_in_reset",  32'(bus.Req_Ready), 0);
    check("midrst_root_x_in_reset", 32'(bus.Root_X),    0);
    next_cycle();
    Rst_n = 1'b1;
    bus.Req_Valid = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      check($sformatf("midrst_valid_c%0d", c), 32'(bus.Res_Valid), 0);
      check($sformatf("midrst_busy_c%0d", c),  32'(bus.Busy),      0);
      next_cycle();
    end
    bus.Req_Valid = 4'b1001;
    sb_q.push_back({2'd0, 4'd7});
    @(negedge Clk);
    check("midrst_first_grant",  32'(bus.Req_Ready), 32'b0001);
    check("midrst_first_root_x", 32'(bus.Root_X),    49);
    next_cycle();
    drain("midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
